// File: rtl/dafx_axi_master.sv
// AXI4-Lite initiator: one command in, one AXI4-Lite transaction out, result held on a
// valid/ready response port. Only one transaction is in flight at a time.
module dafx_axi_master #(
    parameter int AXI_ADDR_WIDTH_P = 16,
    parameter int AXI_DATA_WIDTH_P = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH_P-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH_P-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH_P/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH_P-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [AXI_ADDR_WIDTH_P-1:0]   awaddr,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [AXI_DATA_WIDTH_P-1:0]   wdata,
    output logic [AXI_DATA_WIDTH_P/8-1:0] wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic [1:0]                    bresp,
    input  logic                          bvalid,
    output logic                          bready,
    output logic [AXI_ADDR_WIDTH_P-1:0]   araddr,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [AXI_DATA_WIDTH_P-1:0]   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int STRB_W = AXI_DATA_WIDTH_P / 8;

    typedef enum logic [2:0] {
        IDLE, WRITE, WRESP, READ, RRESP, RESPOND
    } state_t;

    state_t                      state, state_nxt;
    logic                        cmd_ready_nxt, rsp_valid_nxt;
    logic [AXI_DATA_WIDTH_P-1:0] rsp_rdata_nxt;
    logic [1:0]                  rsp_resp_nxt;
    logic [AXI_ADDR_WIDTH_P-1:0] awaddr_nxt, araddr_nxt;
    logic                        awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                        arvalid_nxt, rready_nxt;
    logic [AXI_DATA_WIDTH_P-1:0] wdata_nxt;
    logic [STRB_W-1:0]           wstrb_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_resp  <= rsp_resp_nxt;
            awaddr    <= awaddr_nxt;
            awvalid   <= awvalid_nxt;
            wdata     <= wdata_nxt;
            wstrb     <= wstrb_nxt;
            wvalid    <= wvalid_nxt;
            bready    <= bready_nxt;
            araddr    <= araddr_nxt;
            arvalid   <= arvalid_nxt;
            rready    <= rready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rsp_valid_nxt = rsp_valid;
        rsp_rdata_nxt = rsp_rdata;
        rsp_resp_nxt  = rsp_resp;
        awaddr_nxt    = awaddr;
        awvalid_nxt   = awvalid;
        wdata_nxt     = wdata;
        wstrb_nxt     = wstrb;
        wvalid_nxt    = wvalid;
        bready_nxt    = bready;
        araddr_nxt    = araddr;
        arvalid_nxt   = arvalid;
        rready_nxt    = rready;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WRITE;
                    end else begin
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = READ;
                    end
                end
            end
            WRITE: begin
                // A channel whose valid is already low has completed its beat.
                if (awvalid && awready) awvalid_nxt = 1'b0;
                if (wvalid && wready)   wvalid_nxt  = 1'b0;
                if ((!awvalid || awready) && (!wvalid || wready)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WRESP;
                end
            end
            WRESP: begin
                if (bvalid && bready) begin
                    rsp_resp_nxt  = bresp;
                    rsp_rdata_nxt = '0;
                    bready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESPOND;
                end
            end
            READ: begin
                if (arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RRESP;
                end
            end
            RRESP: begin
                if (rvalid && rready) begin
                    rsp_rdata_nxt = rdata;
                    rsp_resp_nxt  = rresp;
                    rready_nxt    = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Ready only while idle, so a new command lands the cycle after the response leaves.
        cmd_ready_nxt = (state_nxt == IDLE);
    end

endmodule
